// File: rtl/earEEG_pkg.sv
// Shared earEEG definitions: CIC word width helper, frame buffer defaults
// and the read-side FSM encoding.
package earEEG_pkg;

  function automatic int cic_dw(input int bit_w, input int osr);
    return bit_w + 2 * $clog2(osr);
  endfunction

  localparam int DEFAULT_NCH   = 2;
  localparam int DEFAULT_DEPTH = 36;
  localparam int DEFAULT_DW    = cic_dw(12, 64);

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_HELD  = 1'b1;

  typedef enum logic {
    EMPTY = ST_EMPTY,
    HELD  = ST_HELD
  } rd_state_t;

endpackage

// File: rtl/frame_bank_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// No reset on the array or the read register so it maps onto RAM blocks.
module frame_bank_ram
  import earEEG_pkg::*;
#(
  parameter  int WIDTH   = 48,
  parameter  int ENTRIES = 72,
  localparam int AW      = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/cic_frame_buffer.sv
// Ping-pong frame buffer between the CIC decimators and the I2C readout:
// fills one bank while the reader holds the other, swapping on frame completion.
module cic_frame_buffer
  import earEEG_pkg::*;
#(
  parameter  int NCH   = DEFAULT_NCH,
  parameter  int DW    = DEFAULT_DW,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              sample_vld,
  input  logic [NCH*DW-1:0] sample_in,
  input  logic [NCH-1:0]    ch_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [NCH*DW-1:0] rd_data,
  output logic              frame_ready,
  input  logic              frame_ack,
  output logic              overrun,
  input  logic              overrun_clr,
  output logic [7:0]        frame_cnt,
  output logic [AW:0]       wr_fill
);

  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  rd_state_t         state;
  logic              wr_bank;
  logic              rd_bank;
  logic [AW-1:0]     wr_ptr;
  logic [NCH*DW-1:0] masked;
  logic              frame_done;
  logic              swap;
  logic              overrun_set;
  logic              rd_in_range;
  logic              rd_valid_q;
  logic [AW-1:0]     rd_idx;
  logic [AW:0]       wr_ram_addr;
  logic [AW:0]       rd_ram_addr;
  logic [NCH*DW-1:0] ram_q;

  always_comb begin
    masked = '0;
    for (int c = 0; c < NCH; c++) begin
      masked[c*DW +: DW] = ch_en[c] ? sample_in[c*DW +: DW] : '0;
    end
  end

  // An ack arriving with the completing write frees the held bank first, so the swap still happens.
  assign frame_done  = sample_vld && (wr_ptr == LAST_IDX);
  assign swap        = frame_done && ((state == EMPTY) || frame_ack);
  assign overrun_set = frame_done && (state == HELD) && !frame_ack;

  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
  assign rd_idx      = rd_in_range ? rd_addr : '0;
  assign wr_ram_addr = wr_bank ? (DEPTH_W + {1'b0, wr_ptr}) : {1'b0, wr_ptr};
  assign rd_ram_addr = rd_bank ? (DEPTH_W + {1'b0, rd_idx}) : {1'b0, rd_idx};

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      wr_fill <= '0;
    end else if (sample_vld) begin
      if (wr_ptr == LAST_IDX) begin
        wr_ptr  <= '0;
        wr_fill <= '0;
      end else begin
        wr_ptr  <= wr_ptr + 1'b1;
        wr_fill <= wr_fill + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b1;
      frame_ready <= 1'b0;
      frame_cnt   <= '0;
      overrun     <= 1'b0;
    end else begin
      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end

      if (swap) begin
        rd_bank     <= wr_bank;
        wr_bank     <= ~wr_bank;
        frame_ready <= 1'b1;
        frame_cnt   <= frame_cnt + 8'd1;
        state       <= HELD;
      end else if ((state == HELD) && frame_ack) begin
        frame_ready <= 1'b0;
        state       <= EMPTY;
      end
    end
  end

  // The RAM read register has no reset; this flag zeroes rd_data after reset and for out-of-range addresses.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_in_range;
    end
  end

  assign rd_data = rd_valid_q ? ram_q : '0;

  frame_bank_ram #(
    .WIDTH   (NCH * DW),
    .ENTRIES (2 * DEPTH)
  ) u_ram (
    .clk   (sys_clk),
    .we    (sample_vld),
    .waddr (wr_ram_addr),
    .wdata (masked),
    .raddr (rd_ram_addr),
    .rdata (ram_q)
  );

endmodule

// File: doc/cic_frame_buffer.md
Name: cic_frame_buffer

Overview:
- Parametrised ping-pong frame buffer between the per-channel CIC decimators and the I2C slave readout.
- Collects NCH decimated CIC words per FDOWN strobe into frames of DEPTH samples.
- Hands each completed frame to the reader with a ready/ack handshake.
- Flags overruns when the reader has not released the previous frame.

Parameters:
- NCH, 2, number of CIC channels packed per sample slot.
- DW, 24, width of one CIC output word (BIT + 2*clog2(OSR) = 12 + 12).
- DEPTH, 36, samples per frame; legal range 2..64.
- AW, clog2(DEPTH), address width (derived, not overridden).

Ports:
- sys_clk  in  1  system clock, 200 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- sample_vld  in  1  single-cycle sys_clk pulse, one per FDOWN period (edge-detected upstream).
- sample_in  in  NCH*DW  channel words; ch0 in LSBs, ch(NCH-1) in MSBs.
- ch_en  in  NCH  per-channel enable; a disabled channel is stored as zero.
- rd_addr  in  AW  reader sample index within the held frame.
- rd_data  out  NCH*DW  registered read data of the held frame.
- frame_ready  out  1  a complete frame is held for the reader.
- frame_ack  in  1  single-cycle pulse; reader releases the held frame.
- overrun  out  1  sticky; a frame was dropped.
- overrun_clr  in  1  clears overrun.
- frame_cnt  out  8  count of frames delivered; wraps 255 -> 0.
- wr_fill  out  AW+1  samples currently in the write bank.

Behaviour:
- Reset values (all asynchronous on rst_n low):
  - rd_data, frame_ready, overrun, frame_cnt, wr_fill, wr_ptr = 0.
  - wr_bank = 0; read bank = 1.
  - Memory contents are not reset.
- Storage: 2 x DEPTH x (NCH*DW) array. Bank select bit plus AW-bit index.
- Write path:
  - On sample_vld: mem[wr_bank][wr_ptr] <= sample_in with disabled lanes forced to 0. Then wr_ptr++ and wr_fill++.
  - A write with wr_ptr == DEPTH-1 completes a frame. wr_ptr and wr_fill return to 0 in the same cycle.
- Read-side FSM, states EMPTY and HELD:
  - EMPTY, frame completes: read bank <= wr_bank, wr_bank toggles, frame_ready <= 1, frame_cnt++, go to HELD.
  - HELD, frame_ack: frame_ready <= 0, go to EMPTY.
  - HELD, frame completes without ack in the same cycle: overrun <= 1. No swap, no frame_cnt increment; the write bank is refilled from index 0, dropping that frame. The held frame stays intact and readable.
  - HELD, frame_ack and frame completion in the same cycle: ack is applied first, then the swap proceeds. frame_ready stays 1, frame_cnt increments, no overrun.
  - frame_ack while EMPTY is ignored.
- Read path:
  - rd_data <= mem[read bank][rd_addr] each cycle; one cycle of latency.
  - rd_addr >= DEPTH returns 0.
  - Data read while EMPTY is the last released bank (stale, not an error).
- Overrun:
  - Set dominates clear when overrun_clr and an overrun event occur in the same cycle.
  - Otherwise overrun_clr clears it on the next edge.
- sample_vld must not be asserted on consecutive cycles (upstream guarantee). A second pulse is treated as a new sample; no protection is required.
- frame_ready is level and rises exactly one cycle after the DEPTH-th sample_vld. This is the cycle in which the write lands and the swap registers.
- Reset mid-frame: partial frame is discarded; FSM returns to EMPTY with wr_ptr = 0.

Decomposition:
- Shared package earEEG_pkg holds:
  - CIC_DW function (BIT + 2*clog2(OSR)).
  - Default NCH, DEPTH.
  - Localparams for FSM encoding, EMPTY = 1'b0, HELD = 1'b1.
- One sub-module, frame_bank_ram: simple dual-port RAM (1 write, 1 registered read), parametrised by width and depth. It is instantiated once with 2*DEPTH entries so it maps to IGLOO RAM blocks.
- Control (pointer, FSM, counters, masking) stays in cic_frame_buffer.

Test Plan:
- Basic frame:
  - Stimulus: reset, then 36 sample_vld pulses with sample_in = {i, i+1000} (24-bit lanes).
  - Required: frame_ready = 1 one cycle after the 36th pulse; frame_cnt = 1.
  - Required: reading rd_addr 0..35 returns {i, i+1000} with 1-cycle latency.
- Ping-pong:
  - Stimulus: ack the first frame, then write frame 2 with values i+50.
  - Required: frame_cnt = 2 and frame 2 data is read back.
  - Required: during the frame-2 fill, reads from the released bank still return frame-1 data.
- Overrun:
  - Stimulus: no ack, 72 samples.
  - Required: overrun = 1 after sample 72; frame_cnt = 1.
  - Required: the held bank still returns frame-1 values.
  - Stimulus: overrun_clr pulse. Required: overrun = 0.
- Simultaneous ack and completion:
  - Stimulus: frame_ack in the same cycle as the 72nd sample_vld write completes.
  - Required: frame_ready stays 1, frame_cnt = 2, overrun = 0.
- Channel mask:
  - Stimulus: ch_en = 2'b01 with sample_in = {24'hABCDEF, 24'h123456}.
  - Required: stored word = {24'h000000, 24'h123456}.
  - Required: rd_addr = 40 (>= DEPTH) returns 0.
- Reset mid-frame:
  - Stimulus: assert rst_n low after 20 samples.
  - Required: wr_fill = 0, frame_ready = 0, frame_cnt = 0.
  - Required: the next 36 samples produce exactly one frame with those 36 values.
